// File: rtl/prf_wb_arb_pkg.sv
// Shared types for the PRF writeback arbiter. Provides fallback values for the
// global PRF_IDX_W / ZERO_REG defines when the defines header is not in the build.
`ifndef PRF_IDX_W
`define PRF_IDX_W 7
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

package prf_wb_arb_pkg;

    localparam int WB_IDX_W  = `PRF_IDX_W;
    localparam int WB_DATA_W = 64;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_LD   = 2'd2,
        FU_BR   = 2'd3
    } fu_e;

    typedef struct packed {
        logic [WB_IDX_W-1:0]  idx;
        logic [WB_DATA_W-1:0] data;
    } wb_pkt_t;

    // Writes to the hardwired zero register are dropped by the arbiter.
    function automatic logic is_zero_reg(input logic [WB_IDX_W-1:0] idx);
        return idx == WB_IDX_W'(`ZERO_REG);
    endfunction

endpackage

// File: rtl/prf_wb_rr_pick.sv
// Rotating first-one picker: scans req starting at 'start', wrapping at NUM_REQ,
// and returns a one-hot grant plus its encoded index.
module prf_wb_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    logic [PTR_W-1:0] j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = PTR_W'((int'(start) + k) % NUM_REQ);
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j;
            end
        end
    end

endmodule

// File: rtl/prf_wb_arb.sv
// Writeback arbiter for the single PRF write port / CDB broadcast.
// Define PRF_WB_ARB_RR_EN for round-robin; otherwise lowest requester wins.
import prf_wb_arb_pkg::*;

module prf_wb_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = `PRF_IDX_W,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      wr_en_o,
    output logic [IDX_W-1:0]          wr_idx_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic [NUM_REQ-1:0]        grant_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             hold_v;
    logic [NUM_REQ-1:0][IDX_W-1:0]  hold_idx;
    logic [NUM_REQ-1:0][DATA_W-1:0] hold_data;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [PTR_W-1:0]   start;
    logic [NUM_REQ-1:0] accept;

    // Ready comes purely from registered state: a slot is free when empty or
    // being drained this cycle, which is what lets one FU stream every cycle.
    assign req_ready_o = ~hold_v | grant;
    assign accept      = req_valid_i & req_ready_o;

    prf_wb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (hold_v),
        .start     (start),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

`ifdef PRF_WB_ARB_RR_EN
    logic [PTR_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                // A zero-register result is consumed but never occupies the slot.
                if (accept[i])
                    hold_v[i] <= req_idx_i[i*IDX_W +: IDX_W] != IDX_W'(`ZERO_REG);
                else if (grant[i])
                    hold_v[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                hold_idx[i]  <= req_idx_i[i*IDX_W +: IDX_W];
                hold_data[i] <= req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_o   <= 1'b0;
            wr_idx_o  <= '0;
            wr_data_o <= '0;
            grant_o   <= '0;
        end else begin
            wr_en_o <= grant_any;
            grant_o <= grant;
            if (grant_any) begin
                wr_idx_o  <= hold_idx[grant_idx];
                wr_data_o <= hold_data[grant_idx];
            end
        end
    end

endmodule
